// File: rtl/mem_bus_responder_if.sv
// Request/response bus between the CPU memory port and mem_bus_responder.
// The master drives the request fields, the slave answers with Ack/Rdata/Busy/Err.
interface mem_bus_responder_if;
  logic        Req;
  logic [31:0] Addr;
  logic [3:0]  Byte_write;
  logic [31:0] Wdata;
  logic        Ack;
  logic [31:0] Rdata;
  logic        Busy;
  logic        Err;

  modport master (
    output Req, Addr, Byte_write, Wdata,
    input  Ack, Rdata, Busy, Err
  );

  modport slave (
    input  Req, Addr, Byte_write, Wdata,
    output Ack, Rdata, Busy, Err
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Wait-state memory responder: one byte-enabled word access at a time with a single-cycle Ack.
// Optional feature: define MEM_BUS_RESPONDER_RANGE_CHECK_EN to flag and suppress out-of-range accesses.
module mem_bus_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  mem_bus_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    oor_q, oor_d;

  logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0]             mem_word;
  logic [31:0]             merged;
  logic                    mem_we;

  // Byte offset bits never select anything; upper bits only matter with the range check.
  logic                    unused_addr;
  assign unused_addr = ^{bus.Addr[1:0], bus.Addr[31:ADDR_WIDTH+2]};

  assign mem_word = mem[idx_q];

  always_comb begin
    merged = mem_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  assign mem_we = (state_q == S_ACCESS) && !oor_q && (|be_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    oor_d   = oor_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Req) begin
          idx_d   = bus.Addr[ADDR_WIDTH+1:2];
          be_d    = bus.Byte_write;
          wdata_d = bus.Wdata;
          cnt_d   = 4'(WAIT_CYCLES);
`ifdef MEM_BUS_RESPONDER_RANGE_CHECK_EN
          oor_d   = |bus.Addr[31:ADDR_WIDTH+2];
`else
          oor_d   = 1'b0;
`endif
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rdata_d = oor_q ? 32'h0 : merged;
        err_d   = oor_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      oor_q   <= oor_d;
    end
  end

  // Storage is deliberately not reset; reset only ever cancels a pending write.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[idx_q] <= merged;
  end

  assign bus.Ack   = (state_q == S_RESP);
  assign bus.Busy  = (state_q != S_IDLE);
  assign bus.Rdata = rdata_q;
  assign bus.Err   = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed plan steps plus randomized accesses
// compared against a byte-addressed reference memory.
module tb_mem_bus_responder;

  localparam int AW          = 8;
  localparam int W           = 2;
  localparam int DEPTH_BYTES = 4 << AW;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;

  mem_bus_responder_if bus ();
  mem_bus_responder_if bus0 ();

  mem_bus_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  mem_bus_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus0.slave)
  );

  always #5 Clk = ~Clk;

  int check_count = 0;
  int fail_count  = 0;

  logic [7:0]  model_bytes [DEPTH_BYTES];
  logic [31:0] w0_addr [4] = '{32'h10, 32'h14, 32'h10, 32'h14};
  logic [3:0]  w0_be   [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
  logic [31:0] w0_wd   [4] = '{32'hA5A50001, 32'h5A5A0002, 32'h0, 32'h0};
  logic [31:0] w0_exp  [4] = '{32'hA5A50001, 32'h5A5A0002, 32'hA5A50001, 32'h5A5A0002};

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference memory: byte array indexed by the aliased byte address.
  task automatic model_access(input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic err);
    int base;
    bit out_of_range;
    out_of_range = 1'b0;
`ifdef MEM_BUS_RESPONDER_RANGE_CHECK_EN
    out_of_range = (addr >= 32'(DEPTH_BYTES));
`endif
    if (out_of_range) begin
      rd  = 32'h0;
      err = 1'b1;
    end else begin
      base = (int'(addr % 32'(DEPTH_BYTES)) / 4) * 4;
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model_bytes[base + i] = wd[8*i +: 8];
        rd[8*i +: 8] = model_bytes[base + i];
      end
      err = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd, input bit disturb);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          edges;
    bit          busy_ok;
    @(negedge Clk);
    bus.Req        = 1'b1;
    bus.Addr       = addr;
    bus.Byte_write = be;
    bus.Wdata      = wd;
    model_access(addr, be, wd, exp_rd, exp_err);
    @(posedge Clk);
    #1;
    bus.Req = 1'b0;
    check_output("busy_at_capture", 32'(bus.Busy), 32'd1);
    check_output("ack_at_capture", 32'(bus.Ack), 32'd0);
    edges   = 0;
    busy_ok = 1'b1;
    while (edges < 40) begin
      if (disturb) begin
        bus.Req        = 1'($urandom);
        bus.Addr       = $urandom;
        bus.Byte_write = 4'($urandom);
        bus.Wdata      = $urandom;
      end
      @(posedge Clk);
      #1;
      edges++;
      if (!bus.Busy) busy_ok = 1'b0;
      if (bus.Ack === 1'b1) break;
    end
    bus.Req = 1'b0;
    check_output("ack_latency", 32'(edges), 32'(W + 1));
    check_output("busy_while_pending", 32'(busy_ok), 32'd1);
    check_output("rdata", bus.Rdata, exp_rd);
    check_output("err", 32'(bus.Err), 32'(exp_err));
    @(posedge Clk);
    #1;
    check_output("ack_single_cycle", 32'(bus.Ack), 32'd0);
    check_output("busy_after_resp", 32'(bus.Busy), 32'd0);
    check_output("rdata_held", bus.Rdata, exp_rd);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    bus.Req         = 1'b0;
    bus.Addr        = 32'h0;
    bus.Byte_write  = 4'h0;
    bus.Wdata       = 32'h0;
    bus0.Req        = 1'b0;
    bus0.Addr       = 32'h0;
    bus0.Byte_write = 4'h0;
    bus0.Wdata      = 32'h0;

    #2 Rst_n = 1'b0;
    #1;
    check_output("reset_ack", 32'(bus.Ack), 32'd0);
    check_output("reset_busy", 32'(bus.Busy), 32'd0);
    check_output("reset_rdata", bus.Rdata, 32'h0);
    check_output("reset_err", 32'(bus.Err), 32'd0);
    check_output("reset_busy_w0", 32'(bus0.Busy), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    $display("[TB] filling words 0..7");
    for (int k = 0; k < 8; k++) apply_stimulus(32'(k * 4), 4'hF, $urandom, 1'b0);

    $display("[TB] full and partial writes");
    apply_stimulus(32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    check_output("plan_full_write", bus.Rdata, 32'hDEADBEEF);
    apply_stimulus(32'h10, 4'b0010, 32'h0000AA00, 1'b0);
    apply_stimulus(32'h10, 4'h0, 32'hFFFFFFFF, 1'b0);
    check_output("plan_partial_read", bus.Rdata, 32'hDEADAAEF);

    $display("[TB] reset during wait states");
    @(negedge Clk);
    bus.Req        = 1'b1;
    bus.Addr       = 32'h10;
    bus.Byte_write = 4'hF;
    bus.Wdata      = 32'h11111111;
    @(posedge Clk);
    #1;
    bus.Req = 1'b0;
    check_output("abort_busy_capture", 32'(bus.Busy), 32'd1);
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(bus.Busy), 32'd0);
    check_output("abort_ack", 32'(bus.Ack), 32'd0);
    check_output("abort_rdata", bus.Rdata, 32'h0);
    check_output("abort_err", 32'(bus.Err), 32'd0);
    repeat (3) begin
      @(posedge Clk);
      #1;
      check_output("abort_no_ack", 32'(bus.Ack), 32'd0);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    apply_stimulus(32'h10, 4'h0, 32'h0, 1'b0);
    check_output("abort_write_dropped", bus.Rdata, 32'hDEADAAEF);

    $display("[TB] upper address bits");
    apply_stimulus(32'h400, 4'hF, 32'hFFFFFFFF, 1'b0);
`ifdef MEM_BUS_RESPONDER_RANGE_CHECK_EN
    check_output("range_err", 32'(bus.Err), 32'd1);
    check_output("range_rdata", bus.Rdata, 32'h0);
`else
    check_output("alias_err", 32'(bus.Err), 32'd0);
    check_output("alias_rdata", bus.Rdata, 32'hFFFFFFFF);
`endif
    apply_stimulus(32'h0, 4'h0, 32'h0, 1'b0);

    $display("[TB] inputs disturbed while busy");
    apply_stimulus(32'h18, 4'b1001, 32'h12345678, 1'b1);
    apply_stimulus(32'h18, 4'h0, 32'h0, 1'b1);

    $display("[TB] zero wait states, Req held high");
    @(negedge Clk);
    bus0.Req        = 1'b1;
    bus0.Addr       = w0_addr[0];
    bus0.Byte_write = w0_be[0];
    bus0.Wdata      = w0_wd[0];
    for (int j = 0; j < 4; j++) begin
      @(posedge Clk);
      #1;
      check_output("w0_capture_busy", 32'(bus0.Busy), 32'd1);
      check_output("w0_capture_ack", 32'(bus0.Ack), 32'd0);
      if (j < 3) begin
        bus0.Addr       = w0_addr[j + 1];
        bus0.Byte_write = w0_be[j + 1];
        bus0.Wdata      = w0_wd[j + 1];
      end else begin
        bus0.Req = 1'b0;
      end
      @(posedge Clk);
      #1;
      check_output("w0_ack", 32'(bus0.Ack), 32'd1);
      check_output("w0_rdata", bus0.Rdata, w0_exp[j]);
      @(posedge Clk);
      #1;
      check_output("w0_idle_busy", 32'(bus0.Busy), 32'd0);
      check_output("w0_idle_ack", 32'(bus0.Ack), 32'd0);
    end

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      addr = 32'($urandom_range(0, 7)) << 2;
      addr = addr | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr = addr | (32'($urandom_range(1, 4194303)) << 10);
      apply_stimulus(addr, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
